// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB definitions for the two-master arbiter:
//   - HTRANS transfer-type encodings
//   - HBURST burst-type encodings
//   - arbiter FSM state encoding
//   - beat-counter load values per burst length, plus a lookup helper
// ---------------------------------------------------------------------------
package ahb_pkg;

   // Transfer type driven on the muxed address phase
   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   // Burst type driven on the muxed address phase
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_PARK   = 2'b00,  // nobody requesting, default master parked on the bus
      ST_OWN    = 2'b01,  // a requesting master owns the bus
      ST_LOCKED = 2'b10   // owner holds HLOCK, no rearbitration
   } arb_state_e;

   // Beat-counter load values: beats remaining after the NONSEQ beat
   localparam logic [3:0] BEAT_LOAD_NONE = 4'd0;
   localparam logic [3:0] BEAT_LOAD_4    = 4'd3;
   localparam logic [3:0] BEAT_LOAD_8    = 4'd7;
   localparam logic [3:0] BEAT_LOAD_16   = 4'd15;

   function automatic logic [3:0] burst_load(input logic [2:0] hburst);
      logic [3:0] val;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  val = BEAT_LOAD_4;
         HBURST_WRAP8,  HBURST_INCR8:  val = BEAT_LOAD_8;
         HBURST_WRAP16, HBURST_INCR16: val = BEAT_LOAD_16;
         default:                      val = BEAT_LOAD_NONE;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/ahb_burst_cnt.sv
// ---------------------------------------------------------------------------
// ahb_burst_cnt
// Tracks the beats of a fixed-length burst on the muxed address phase and
// flags the beat on which the arbiter may hand the bus over.
//
// Ports
//   clk        in   bus clock
//   rst        in   synchronous active-high reset (clears the count)
//   hready     in   bus-wide ready; a beat is accepted only when high
//   htrans     in   transfer type of the current address phase
//   hburst     in   burst type of the current address phase
//   count      out  beats still expected after the current one
//   last_beat  out  the current address phase is an accepted final beat
//   busy       out  a fixed-length burst is in progress (count != 0)
// ---------------------------------------------------------------------------
module ahb_burst_cnt
   import ahb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       hready,
   input  logic [1:0] htrans,
   input  logic [2:0] hburst,
   output logic [3:0] count,
   output logic       last_beat,
   output logic       busy
);

   logic acc_nonseq;
   logic acc_seq;

   assign acc_nonseq = hready && (htrans == HTRANS_NONSEQ);
   assign acc_seq    = hready && (htrans == HTRANS_SEQ);

   // A SINGLE is complete on its NONSEQ beat. INCR also loads zero but is
   // open-ended, so it is never flagged here; its SEQ beats find count=0 and
   // neither decrement nor terminate.
   assign last_beat = (acc_nonseq && (hburst == HBURST_SINGLE)) ||
                      (acc_seq && (count == 4'd1));

   assign busy = (count != 4'd0);

   // BUSY, IDLE and wait states all leave the count untouched
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (acc_nonseq) begin
         count <= burst_load(hburst);
      end else if (acc_seq && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

endmodule

// File: rtl/ahb_arbiter_m2.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_m2
// Two-master AHB bus arbiter with parking, burst-aware handover and locked
// transfers. HGRANT is decoded from a registered owner index, so it is
// one-hot in every cycle and changes one cycle after the arbitration
// decision.
//
// Configuration macro: AHB_ARB_ROUND_ROBIN_EN
//   defined   -> ties go to the master not served last (last-served pointer)
//   undefined -> fixed priority, master 0 wins ties
//
// Parameter
//   DEFAULT_MASTER  master parked on the bus when nobody requests
//
// Ports
//   HCLK            in   bus clock, rising edge
//   HRESET          in   synchronous active-high reset
//   HBUSREQ[1:0]    in   per-master bus request
//   HLOCK[1:0]      in   per-master locked-transfer request
//   HTRANS[1:0]     in   transfer type of the muxed address phase
//   HBURST[2:0]     in   burst type of the muxed address phase
//   HREADY          in   bus-wide ready; nothing changes while low
//   HGRANT[1:0]     out  one-hot grant
//   HMASTER         out  master owning the current address phase
//   HMASTLOCK       out  lock status of the current address phase
//   dbg_state       out  FSM state
//   dbg_beat_cnt    out  beat counter value
//   dbg_burst_busy  out  fixed-length burst in progress
//
// Handshake: a transfer phase is accepted on a rising edge where HREADY=1.
// Every state, grant, HMASTER and HMASTLOCK update is qualified by that
// acceptance, so all of them hold through wait states.
// ---------------------------------------------------------------------------
module ahb_arbiter_m2
   import ahb_pkg::*;
#(
   parameter int DEFAULT_MASTER = 0
)
(
   input  logic       HCLK,
   input  logic       HRESET,
   input  logic [1:0] HBUSREQ,
   input  logic [1:0] HLOCK,
   input  logic [1:0] HTRANS,
   input  logic [2:0] HBURST,
   input  logic       HREADY,
   output logic [1:0] HGRANT,
   output logic       HMASTER,
   output logic       HMASTLOCK,
   output arb_state_e dbg_state,
   output logic [3:0] dbg_beat_cnt,
   output logic       dbg_burst_busy
);

   localparam logic DM = 1'(DEFAULT_MASTER);

   arb_state_e state_q, state_d;
   logic       owner_q, owner_d;
   logic       hmaster_q;
   logic       hmastlock_q;
   logic       winner;
   logic       arb_now;
   logic       last_beat;
   logic       trans_idle;

   ahb_burst_cnt u_burst_cnt (
      .clk       (HCLK),
      .rst       (HRESET),
      .hready    (HREADY),
      .htrans    (HTRANS),
      .hburst    (HBURST),
      .count     (dbg_beat_cnt),
      .last_beat (last_beat),
      .busy      (dbg_burst_busy)
   );

   assign trans_idle = (HTRANS == HTRANS_IDLE);

   // Arbitration happens this cycle: always while parked, in OWN only at a
   // handover point (unless the owner is asking for a lock, which wins),
   // and in LOCKED only once the owner releases the lock on an IDLE phase.
   always_comb begin
      arb_now = 1'b0;
      if (HREADY) begin
         case (state_q)
            ST_PARK:   arb_now = 1'b1;
            ST_OWN:    arb_now = !HLOCK[owner_q] &&
                                 (!HBUSREQ[owner_q] || trans_idle || last_beat);
            ST_LOCKED: arb_now = !HLOCK[owner_q] && trans_idle;
            default:   arb_now = 1'b0;
         endcase
      end
   end

   // Winner among requesters; only meaningful when some HBUSREQ is set
`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic last_srv_q;

   always_comb begin
      winner = ~HBUSREQ[0];
      if (&HBUSREQ) begin
         winner = ~last_srv_q;
      end
   end

   // Moves on every award to a requester, even if the owner is unchanged,
   // so that a parked master that wins a tie yields the next one.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         last_srv_q <= 1'b1;
      end else if (arb_now && (|HBUSREQ)) begin
         last_srv_q <= winner;
      end
   end
`else
   assign winner = ~HBUSREQ[0];
`endif

   // FSM next state and next owner
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      case (state_q)
         ST_PARK, ST_OWN, ST_LOCKED: begin
            if (arb_now) begin
               if (|HBUSREQ) begin
                  state_d = ST_OWN;
                  owner_d = winner;
               end else begin
                  state_d = ST_PARK;
                  owner_d = DM;
               end
            end else if ((state_q == ST_OWN) && HREADY && HLOCK[owner_q]) begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_PARK;
            owner_d = DM;
         end
      endcase
   end

   // FSM state register, owner and address-phase ownership
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_PARK;
         owner_q     <= DM;
         hmaster_q   <= DM;
         hmastlock_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         // The master granted at an accepting edge owns the next address phase
         if (HREADY) begin
            hmaster_q   <= owner_q;
            hmastlock_q <= HLOCK[owner_q];
         end
      end
   end

   assign HGRANT    = owner_q ? 2'b10 : 2'b01;
   assign HMASTER   = hmaster_q;
   assign HMASTLOCK = hmastlock_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_ahb_arbiter_m2.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_m2
// Directed bench for ahb_arbiter_m2 (DEFAULT_MASTER = 0). Each drive call
// applies one cycle of inputs, advances past the rising edge and the
// following checks look at the registered outputs for the next cycle.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_m2;
   import ahb_pkg::*;

   logic       HCLK;
   logic       HRESET;
   logic [1:0] HBUSREQ;
   logic [1:0] HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [1:0] HGRANT;
   logic       HMASTER;
   logic       HMASTLOCK;
   arb_state_e dbg_state;
   logic [3:0] dbg_beat_cnt;
   logic       dbg_burst_busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [1:0] exp_q[$];

   ahb_arbiter_m2 #(.DEFAULT_MASTER(0)) dut (
      .HCLK           (HCLK),
      .HRESET         (HRESET),
      .HBUSREQ        (HBUSREQ),
      .HLOCK          (HLOCK),
      .HTRANS         (HTRANS),
      .HBURST         (HBURST),
      .HREADY         (HREADY),
      .HGRANT         (HGRANT),
      .HMASTER        (HMASTER),
      .HMASTLOCK      (HMASTLOCK),
      .dbg_state      (dbg_state),
      .dbg_beat_cnt   (dbg_beat_cnt),
      .dbg_burst_busy (dbg_burst_busy)
   );

   // clock / reset block
   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   // driver: one bus cycle, then sample 1 time unit after the edge
   task automatic drive(input logic [1:0] req, input logic [1:0] lock,
                        input logic [1:0] trans, input logic [2:0] burst,
                        input logic rdy);
      HBUSREQ = req;
      HLOCK   = lock;
      HTRANS  = trans;
      HBURST  = burst;
      HREADY  = rdy;
      @(posedge HCLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      HRESET  = 1'b1;
      HBUSREQ = 2'b00;
      HLOCK   = 2'b00;
      HTRANS  = HTRANS_IDLE;
      HBURST  = HBURST_SINGLE;
      HREADY  = 1'b1;

      // ---- reset with no requests ----
      drive(2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      drive(2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      check("rst_grant",    32'(HGRANT),       32'h1);
      check("rst_hmaster",  32'(HMASTER),      32'h0);
      check("rst_mastlock", 32'(HMASTLOCK),    32'h0);
      check("rst_state",    32'(dbg_state),    32'(ST_PARK));
      check("rst_cnt",      32'(dbg_beat_cnt), 32'h0);
      HRESET = 1'b0;
      drive(2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      check("park_idle_grant", 32'(HGRANT), 32'h1);

      // ---- M1 INCR4, M0 requests from beat 2 ----
      drive(2'b10, 2'b00, HTRANS_IDLE,   HBURST_INCR4, 1'b1);
      check("i4_grant_c1",  32'(HGRANT),    32'h2);
      check("i4_state_c1",  32'(dbg_state), 32'(ST_OWN));
      drive(2'b10, 2'b00, HTRANS_IDLE,   HBURST_INCR4, 1'b1);
      check("i4_hmaster",   32'(HMASTER),   32'h1);
      drive(2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR4, 1'b1);
      check("i4_cnt_b1",    32'(dbg_beat_cnt), 32'd3);
      check("i4_busy_b1",   32'(dbg_burst_busy), 32'h1);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR4, 1'b1);
      check("i4_cnt_b2",    32'(dbg_beat_cnt), 32'd2);
      check("i4_grant_b2",  32'(HGRANT),    32'h2);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR4, 1'b1);
      check("i4_cnt_b3",    32'(dbg_beat_cnt), 32'd1);
      check("i4_grant_b3",  32'(HGRANT),    32'h2);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR4, 1'b1);
      check("i4_grant_after", 32'(HGRANT),  32'h1);
      check("i4_cnt_after",   32'(dbg_beat_cnt), 32'd0);
      check("i4_hmaster_b4",  32'(HMASTER), 32'h1);
      drive(2'b01, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("i4_hmaster_m0",  32'(HMASTER), 32'h0);
      check("i4_grant_m0",    32'(HGRANT),  32'h1);
      drive(2'b00, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("i4_back_park",   32'(dbg_state), 32'(ST_PARK));

      // ---- M1 INCR8 with wait states and a BUSY ----
      drive(2'b10, 2'b00, HTRANS_IDLE,   HBURST_INCR8, 1'b1);
      check("i8_grant_c1", 32'(HGRANT), 32'h2);
      drive(2'b10, 2'b00, HTRANS_IDLE,   HBURST_INCR8, 1'b1);
      drive(2'b10, 2'b00, HTRANS_NONSEQ, HBURST_INCR8, 1'b1);
      check("i8_cnt_b1", 32'(dbg_beat_cnt), 32'd7);
      drive(2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      drive(2'b10, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      check("i8_cnt_b3", 32'(dbg_beat_cnt), 32'd5);
      // owner drops its request during the waits: must be ignored
      for (int i = 0; i < 3; i++) begin
         drive(2'b01, 2'b00, HTRANS_SEQ, HBURST_INCR8, 1'b0);
         check("i8_cnt_wait",   32'(dbg_beat_cnt), 32'd5);
         check("i8_grant_wait", 32'(HGRANT),       32'h2);
      end
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      check("i8_cnt_b4", 32'(dbg_beat_cnt), 32'd4);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      drive(2'b11, 2'b00, HTRANS_BUSY,   HBURST_INCR8, 1'b1);
      check("i8_cnt_busy",   32'(dbg_beat_cnt), 32'd3);
      check("i8_grant_busy", 32'(HGRANT),       32'h2);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      check("i8_cnt_b7",   32'(dbg_beat_cnt), 32'd1);
      check("i8_grant_b7", 32'(HGRANT),       32'h2);
      drive(2'b11, 2'b00, HTRANS_SEQ,    HBURST_INCR8, 1'b1);
      check("i8_grant_after", 32'(HGRANT),       32'h1);
      check("i8_cnt_after",   32'(dbg_beat_cnt), 32'd0);
      drive(2'b00, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("i8_back_park",   32'(dbg_state), 32'(ST_PARK));

      // ---- both masters streaming SINGLE transfers ----
`ifdef AHB_ARB_ROUND_ROBIN_EN
      exp_q = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
`else
      exp_q = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
`endif
      for (int i = 0; i < 6; i++) begin
         drive(2'b11, 2'b00, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
         check("single_grant", 32'(HGRANT), 32'(exp_q.pop_front()));
      end
      drive(2'b00, 2'b00, HTRANS_IDLE, HBURST_SINGLE, 1'b1);
      check("single_park", 32'(dbg_state), 32'(ST_PARK));

      // ---- M1 locked, M0 waiting ----
      drive(2'b10, 2'b10, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("lk_grant_c1", 32'(HGRANT),    32'h2);
      drive(2'b10, 2'b10, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("lk_state",    32'(dbg_state), 32'(ST_LOCKED));
      check("lk_mastlock", 32'(HMASTLOCK), 32'h1);
      drive(2'b11, 2'b10, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1);
      check("lk_grant_single", 32'(HGRANT),    32'h2);
      drive(2'b11, 2'b10, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("lk_grant_idle",   32'(HGRANT),    32'h2);
      check("lk_mastlock_idle",32'(HMASTLOCK), 32'h1);
      drive(2'b01, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);
      check("lk_grant_rel",    32'(HGRANT),    32'h1);
      check("lk_mastlock_rel", 32'(HMASTLOCK), 32'h0);
      check("lk_state_rel",    32'(dbg_state), 32'(ST_OWN));
      drive(2'b00, 2'b00, HTRANS_IDLE,   HBURST_SINGLE, 1'b1);

      // ---- reset during beat 3 of a locked M1 WRAP16 ----
      drive(2'b10, 2'b10, HTRANS_IDLE,   HBURST_WRAP16, 1'b1);
      drive(2'b10, 2'b10, HTRANS_IDLE,   HBURST_WRAP16, 1'b1);
      drive(2'b10, 2'b10, HTRANS_NONSEQ, HBURST_WRAP16, 1'b1);
      check("w16_cnt_b1", 32'(dbg_beat_cnt), 32'd15);
      drive(2'b10, 2'b10, HTRANS_SEQ,    HBURST_WRAP16, 1'b1);
      check("w16_cnt_b2",   32'(dbg_beat_cnt), 32'd14);
      check("w16_mastlock", 32'(HMASTLOCK),    32'h1);
      HRESET = 1'b1;
      drive(2'b10, 2'b10, HTRANS_SEQ,    HBURST_WRAP16, 1'b1);
      HRESET = 1'b0;
      check("w16_rst_grant",    32'(HGRANT),       32'h1);
      check("w16_rst_mastlock", 32'(HMASTLOCK),    32'h0);
      check("w16_rst_cnt",      32'(dbg_beat_cnt), 32'd0);
      check("w16_rst_state",    32'(dbg_state),    32'(ST_PARK));
      check("w16_rst_hmaster",  32'(HMASTER),      32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
